// File: rtl/led_scan_pkg.sv
// Shared types and constants for the HUB75 scan driver.
// LED_SCANNER_REGISTERED_PAINTER_EN selects a painter whose rgb lags x/y by one cycle.
package led_scan_pkg;

   typedef enum logic [1:0] {
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_UNBLANK
   } scan_state_t;

   localparam int WIDTH     = 64;
   localparam int HALF_ROWS = 32;

   localparam int PIN_R0    = 0;
   localparam int PIN_G0    = 1;
   localparam int PIN_B0    = 2;
   localparam int PIN_R1    = 3;
   localparam int PIN_G1    = 4;
   localparam int PIN_B1    = 5;
   localparam int PIN_ADDR  = 6;
   localparam int ADDR_BITS = 5;
   localparam int PIN_CLK   = 11;
   localparam int PIN_LAT   = 12;
   localparam int PIN_OE_N  = 13;

`ifdef LED_SCANNER_REGISTERED_PAINTER_EN
   localparam int PAINTER_LAG = 1;
`else
   localparam int PAINTER_LAG = 0;
`endif

   // Every column spends one extra cycle when the painter output is registered.
   localparam int COL_CYCLES = 4 + PAINTER_LAG;

endpackage

// File: rtl/led_scanner.sv
// HUB75 scan driver for a 64x64 panel: walks coordinates for the painter and shifts/latches rows.
// Build option LED_SCANNER_REGISTERED_PAINTER_EN (see led_scan_pkg) stretches each column to 5 cycles.
module led_scanner
   import led_scan_pkg::*;
#(
   parameter int SUBFRAMES = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic [12:0] frame,
   output logic [7:0]  subframe,
   output logic [5:0]  x,
   output logic [5:0]  y,
   input  logic [2:0]  rgb,
   output logic [15:0] LED_PANEL
);

   localparam int PH_W = 3;
   localparam logic [PH_W-1:0] PH_FIRST = '0;
   localparam logic [PH_W-1:0] PH_TOP   = PH_W'(PAINTER_LAG);
   localparam logic [PH_W-1:0] PH_BOT   = PH_W'(PAINTER_LAG + 1);
   localparam logic [PH_W-1:0] PH_DATA  = PH_W'(PAINTER_LAG + 2);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(COL_CYCLES - 1);
   localparam logic [7:0]      SUB_LAST = 8'(SUBFRAMES - 1);
   localparam logic [5:0]      COL_LAST = 6'(WIDTH - 1);
   localparam logic [4:0]      ROW_LAST = 5'(HALF_ROWS - 1);

   scan_state_t     state;
   logic [PH_W-1:0] phase;
   logic [5:0]      col;
   logic [4:0]      row;
   logic [2:0]      top_q;
   logic [5:0]      pix_q;
   logic [4:0]      addr_q;
   logic            clk_q;
   logic            lat_q;
   logic            oe_n_q;

   // The state names the cycle in progress; every edge loads the pin values for the next cycle,
   // so x/y and the panel pins are always plain flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_SHIFT;
         phase    <= '0;
         col      <= '0;
         row      <= '0;
         frame    <= '0;
         subframe <= '0;
         x        <= '0;
         y        <= '0;
         top_q    <= '0;
         pix_q    <= '0;
         addr_q   <= '0;
         clk_q    <= 1'b0;
         lat_q    <= 1'b0;
         oe_n_q   <= 1'b1;
      end else begin
         case (state)
            ST_SHIFT: begin
               phase <= phase + PH_W'(1);
               if (phase == PH_FIRST)
                  y <= {1'b1, row};
               if (phase == PH_TOP)
                  top_q <= rgb;
               if (phase == PH_BOT) begin
                  pix_q <= {rgb, top_q};
                  clk_q <= 1'b0;
               end
               if (phase == PH_DATA)
                  clk_q <= 1'b1;
               if (phase == PH_LAST) begin
                  phase <= '0;
                  clk_q <= 1'b0;
                  if (col == COL_LAST) begin
                     state  <= ST_BLANK;
                     oe_n_q <= 1'b1;
                  end else begin
                     col <= col + 6'd1;
                     x   <= col + 6'd1;
                     y   <= {1'b0, row};
                  end
               end
            end
            ST_BLANK: begin
               state  <= ST_LATCH;
               lat_q  <= 1'b1;
               addr_q <= row;
            end
            ST_LATCH: begin
               state  <= ST_UNBLANK;
               lat_q  <= 1'b0;
               oe_n_q <= 1'b0;
            end
            ST_UNBLANK: begin
               state <= ST_SHIFT;
               col   <= '0;
               x     <= '0;
               row   <= row + 5'd1;
               y     <= {1'b0, row + 5'd1};
               if (row == ROW_LAST) begin
                  if (subframe == SUB_LAST) begin
                     subframe <= '0;
                     frame    <= frame + 13'd1;
                  end else begin
                     subframe <= subframe + 8'd1;
                  end
               end
            end
            default: state <= ST_SHIFT;
         endcase
      end
   end

   always_comb begin
      LED_PANEL                          = '0;
      LED_PANEL[PIN_B1:PIN_R0]           = pix_q;
      LED_PANEL[PIN_ADDR +: ADDR_BITS]   = addr_q;
      LED_PANEL[PIN_CLK]                 = clk_q;
      LED_PANEL[PIN_LAT]                 = lat_q;
      LED_PANEL[PIN_OE_N]                = oe_n_q;
   end

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: reset release, column data, row latching, counter wrap, mid-row reset.
// Follows LED_SCANNER_REGISTERED_PAINTER_EN to model the painter with or without an output register.
module tb_led_scanner;
   import led_scan_pkg::*;

   localparam int SUBF = 2;
   localparam int ROWP = WIDTH * COL_CYCLES + 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [12:0] frame;
   logic [7:0]  subframe;
   logic [5:0]  x;
   logic [5:0]  y;
   logic [2:0]  rgb;
   logic [15:0] LED_PANEL;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_scanner #(.SUBFRAMES(SUBF)) dut (
      .clk       (clk),
      .reset     (reset),
      .frame     (frame),
      .subframe  (subframe),
      .x         (x),
      .y         (y),
      .rgb       (rgb),
      .LED_PANEL (LED_PANEL)
   );

   // Painter: red follows column parity in the top half, bottom half is solid blue.
   function automatic logic [2:0] paint(input logic [5:0] px, input logic [5:0] py);
      return (py < 6'd32) ? {2'b00, px[0]} : 3'b100;
   endfunction

`ifdef LED_SCANNER_REGISTERED_PAINTER_EN
   always_ff @(posedge clk) rgb <= paint(x, y);
`else
   assign rgb = paint(x, y);
`endif

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic rst, input int cycles);
      reset = rst;
      repeat (cycles) @(negedge clk);
   endtask

   // Rows are numbered from the last reset; each iteration samples one cycle at the negedge.
   task automatic run_rows(input int r_first, input int r_last);
      for (int r = r_first; r < r_last; r++) begin
         int         phys = r % HALF_ROWS;
         int         prev_addr = (r == 0) ? 0 : (r - 1) % HALF_ROWS;
         int         rises = 0;
         int         data_bad = 0;
         int         xy_bad = 0;
         int         shift_bad = 0;
         logic       prev_clk = 1'b0;
         logic [5:0] prev_data = '0;
         check_output($sformatf("frame r%0d", r), 32'(frame), 32'(r / (HALF_ROWS * SUBF)));
         check_output($sformatf("subframe r%0d", r), 32'(subframe), 32'((r / HALF_ROWS) % SUBF));
         for (int t = 0; t < ROWP; t++) begin
            logic [7:0] ctrl;
            logic [5:0] data;
            ctrl = LED_PANEL[13:6];
            data = LED_PANEL[5:0];
            if (t < WIDTH * COL_CYCLES) begin
               if (ctrl[7] !== (r == 0) || ctrl[6] !== 1'b0 || ctrl[4:0] !== 5'(prev_addr)
                   || LED_PANEL[15:14] !== 2'b00)
                  shift_bad++;
               if (t % COL_CYCLES == 0 && (x !== 6'(t / COL_CYCLES) || y !== 6'(phys)))
                  xy_bad++;
               if (t % COL_CYCLES == 1 && (x !== 6'(t / COL_CYCLES) || y !== 6'(phys + 32)))
                  xy_bad++;
               if (ctrl[5] && !prev_clk) begin
                  if (data !== {3'b100, 2'b00, 1'(rises)} || data !== prev_data)
                     data_bad++;
                  rises++;
               end
            end
            if (t == ROWP - 3)
               check_output($sformatf("blank_ctrl r%0d", r), 32'(ctrl), 32'({3'b100, 5'(prev_addr)}));
            if (t == ROWP - 2)
               check_output($sformatf("latch_ctrl r%0d", r), 32'(ctrl), 32'({3'b110, 5'(phys)}));
            if (t == ROWP - 1)
               check_output($sformatf("unblank_ctrl r%0d", r), 32'(ctrl), 32'({3'b000, 5'(phys)}));
            prev_clk  = ctrl[5];
            prev_data = data;
            @(negedge clk);
         end
         check_output($sformatf("clk_rises r%0d", r), 32'(rises), 32'(WIDTH));
         check_output($sformatf("pixel_data r%0d", r), 32'(data_bad), 32'(0));
         check_output($sformatf("coords r%0d", r), 32'(xy_bad), 32'(0));
         check_output($sformatf("shift_ctrl r%0d", r), 32'(shift_bad), 32'(0));
      end
   endtask

   initial begin
      apply_stimulus(1'b1, 3);
      check_output("reset_panel", 32'(LED_PANEL), 32'h0000_2000);
      check_output("reset_frame", 32'(frame), 32'(0));
      check_output("reset_subframe", 32'(subframe), 32'(0));
      check_output("reset_x", 32'(x), 32'(0));
      check_output("reset_y", 32'(y), 32'(0));
      reset = 1'b0;

      // Two full subframes, then into the next frame up to physical row 5.
      run_rows(0, 64);
      run_rows(64, 69);

      repeat (30 * COL_CYCLES) @(negedge clk);
      check_output("midrow_x", 32'(x), 32'(30));
      check_output("midrow_y", 32'(y), 32'(5));
      check_output("midrow_frame", 32'(frame), 32'(1));
      repeat (2) @(negedge clk);

      apply_stimulus(1'b1, 1);
      check_output("abort_panel", 32'(LED_PANEL), 32'h0000_2000);
      check_output("abort_x", 32'(x), 32'(0));
      check_output("abort_y", 32'(y), 32'(0));
      check_output("abort_frame", 32'(frame), 32'(0));
      check_output("abort_subframe", 32'(subframe), 32'(0));
      reset = 1'b0;

      run_rows(0, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
